// File: rtl/prbs_mode_checker.sv
// Self-synchronising PRBS7/9/15/23/31 checker with lock hysteresis and
// saturating error-bit / lock-loss counters. Bit 0 of each word is first in time.
module prbs_mode_checker #(
  parameter int DATA_WIDTH   = 64,
  parameter int CNT_WIDTH    = 32,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [2:0]                      cfg_mode,
  input  logic                            cfg_invert,
  input  logic                            cfg_clear,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            lock,
  output logic                            err_valid,
  output logic [$clog2(DATA_WIDTH+1)-1:0] err_bits,
  output logic [CNT_WIDTH-1:0]            err_count,
  output logic [7:0]                      lock_loss_count
);
  localparam int MAX_TAP = 31;
  localparam int EB_W    = $clog2(DATA_WIDTH + 1);
  localparam int GC_W    = $clog2(LOCK_COUNT + 1);
  localparam int BC_W    = $clog2(UNLOCK_COUNT + 1);
  localparam int EXT_W   = DATA_WIDTH + MAX_TAP;

  localparam logic ST_HUNT   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic                  state_q, state_d;
  logic [GC_W-1:0]       good_q, good_d;
  logic [BC_W-1:0]       bad_q, bad_d;
  logic [2:0]            fill_q, fill_d;
  logic [MAX_TAP-1:0]    hist_q, hist_d;
  logic [2:0]            mode_q;
  logic                  invert_q;
  logic                  cfg_seen_q;
  logic                  err_valid_q, err_valid_d;
  logic [EB_W-1:0]       err_bits_q, err_bits_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [7:0]            lock_loss_q, lock_loss_d;

  logic [4:0]            tap_a, tap_b;
  logic                  cfg_change, hist_full, evaluate, loss_event;
  logic [DATA_WIDTH-1:0] data_eff, pred_a, pred_b, err_vec;
  logic [EXT_W-1:0]      ext;
  logic [EB_W-1:0]       pop;
  logic [CNT_WIDTH:0]    sum;

  always_comb begin
    case (cfg_mode)
      3'd0:    begin tap_a = 5'd7;  tap_b = 5'd6;  end
      3'd1:    begin tap_a = 5'd9;  tap_b = 5'd5;  end
      3'd2:    begin tap_a = 5'd15; tap_b = 5'd14; end
      3'd3:    begin tap_a = 5'd23; tap_b = 5'd18; end
      default: begin tap_a = 5'd31; tap_b = 5'd28; end
    endcase
  end

  // cfg_seen_q masks the first clock after reset, when mode_q/invert_q hold reset values.
  assign cfg_change = cfg_seen_q && ((cfg_mode != mode_q) || (cfg_invert != invert_q));
  assign data_eff   = in_data ^ {DATA_WIDTH{cfg_invert}};

  // ext[MAX_TAP+i] is word bit i; shifting down by (31-A) lines up d[n-A] with bit n.
  assign ext     = {data_eff, hist_q};
  assign pred_a  = DATA_WIDTH'(ext >> (5'd31 - tap_a));
  assign pred_b  = DATA_WIDTH'(ext >> (5'd31 - tap_b));
  assign err_vec = data_eff ^ pred_a ^ pred_b;

  assign hist_full = (int'(fill_q) * DATA_WIDTH) >= int'(tap_a);
  assign evaluate  = in_valid && !cfg_change && hist_full;

  always_comb begin
    // NOTE: blocking '=' in combinational logic so each iteration sees the running sum.
    pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pop = pop + EB_W'(err_vec[i]);
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its hold value first, so no path infers a latch.
    state_d     = state_q;
    good_d      = good_q;
    bad_d       = bad_q;
    fill_d      = fill_q;
    hist_d      = hist_q;
    err_valid_d = evaluate;
    err_bits_d  = evaluate ? pop : err_bits_q;
    loss_event  = 1'b0;
    if (cfg_change) begin
      state_d = ST_HUNT;
      good_d  = '0;
      bad_d   = '0;
      fill_d  = '0;
    end else if (in_valid) begin
      hist_d = ext[EXT_W-1:DATA_WIDTH];
      if (!hist_full) begin
        fill_d = fill_q + 3'd1;
      end else if (state_q == ST_HUNT) begin
        if (pop == '0) begin
          good_d = good_q + GC_W'(1);
          if (good_d == GC_W'(LOCK_COUNT)) begin
            state_d = ST_LOCKED;
            bad_d   = '0;
          end
        end else begin
          good_d = '0;
        end
      end else begin
        if (pop != '0) begin
          bad_d = bad_q + BC_W'(1);
          if (bad_d == BC_W'(UNLOCK_COUNT)) begin
            state_d    = ST_HUNT;
            good_d     = '0;
            loss_event = 1'b1;
          end
        end else begin
          bad_d = '0;
        end
      end
    end
  end

  assign sum = {1'b0, err_count_q} + (CNT_WIDTH + 1)'(pop);

  always_comb begin
    err_count_d = err_count_q;
    lock_loss_d = lock_loss_q;
    if (cfg_clear) begin
      err_count_d = '0;
      lock_loss_d = '0;
    end else begin
      if (evaluate && (state_q == ST_LOCKED)) begin
        err_count_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      end
      if (loss_event && (lock_loss_q != 8'hFF)) begin
        lock_loss_d = lock_loss_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      good_q      <= '0;
      bad_q       <= '0;
      fill_q      <= '0;
      // NOTE: the history is a handful of flops, not a RAM, so it takes the async reset too.
      hist_q      <= '0;
      mode_q      <= '0;
      invert_q    <= 1'b0;
      cfg_seen_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_bits_q  <= '0;
      err_count_q <= '0;
      lock_loss_q <= '0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      fill_q      <= fill_d;
      hist_q      <= hist_d;
      mode_q      <= cfg_mode;
      invert_q    <= cfg_invert;
      cfg_seen_q  <= 1'b1;
      err_valid_q <= err_valid_d;
      err_bits_q  <= err_bits_d;
      err_count_q <= err_count_d;
      lock_loss_q <= lock_loss_d;
    end
  end

  assign lock            = state_q;
  assign err_valid       = err_valid_q;
  assign err_bits        = err_bits_q;
  assign err_count       = err_count_q;
  assign lock_loss_count = lock_loss_q;

endmodule
